// File: rtl/atconv_pool_engine_if.sv
// Handshake, image ROM and result-bank bus of the atrous-convolution engine.
// The engine drives the master side; ROM, banks and the start source sit on the slave side.
interface atconv_pool_engine_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 13
) ();
  logic                     ready;
  logic                     busy;
  logic                     done;
  logic [ADDR_W-1:0]        iaddr;
  logic signed [DATA_W-1:0] idata;
  logic                     cwr;
  logic [ADDR_W-1:0]        caddr_wr;
  logic signed [DATA_W-1:0] cdata_wr;
  logic                     crd;
  logic [ADDR_W-1:0]        caddr_rd;
  logic signed [DATA_W-1:0] cdata_rd;
  logic                     csel;

  modport master (
    input  ready, idata, cdata_rd,
    output busy, done, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );

  modport slave (
    output ready, idata, cdata_rd,
    input  busy, done, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );
endinterface

// File: rtl/atconv_pool_engine.sv
// Dilated 3x3 high-pass convolution with bias/ReLU into bank 0, then optional
// 2x2 max-pool with round-up into bank 1.
//
// state  | meaning
// IDLE   | waiting for ready
// CONV   | 11-cycle pass per pixel: 9 tap fetches, accumulate, write bank 0
// POOL   | 6-cycle pass per output: 4 bank-0 reads, running max, write bank 1
// DONE   | one-cycle done pulse, then back to IDLE
module atconv_pool_engine #(
  parameter int IMG_W    = 64,
  parameter int IMG_H    = 64,
  parameter int DATA_W   = 13,
  parameter int FRAC_W   = 4,
  parameter int ADDR_W   = 12,
  parameter int DILATION = 2,
  parameter int BIAS     = -12,
  parameter int POOL_EN  = 1
) (
  input logic clk,
  input logic reset,
  atconv_pool_engine_if.master bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_POOL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int ACC_W = DATA_W + 4;
  localparam int MAX_V = 2**(DATA_W-1) - 1;
  localparam logic signed [ACC_W-1:0] BIAS_A = ACC_W'(BIAS);
  localparam logic signed [ACC_W-1:0] MAX_A  = ACC_W'(MAX_V);
  localparam logic [DATA_W:0] MAX_U = (DATA_W+1)'(MAX_V);
  localparam logic [DATA_W:0] RND_U = (DATA_W+1)'(2**FRAC_W - 1);
  localparam logic [ADDR_W-1:0] CONV_XL = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] CONV_YL = ADDR_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] POOL_XL = ADDR_W'(IMG_W/2 - 1);
  localparam logic [ADDR_W-1:0] POOL_YL = ADDR_W'(IMG_H/2 - 1);

  logic [1:0]               state;
  logic [3:0]               phase;
  logic [ADDR_W-1:0]        x, y, pix;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] mx;

  logic              x_last, y_last;
  logic [ADDR_W-1:0] nx, ny;

  always_comb begin
    x_last = (state == S_POOL) ? (x == POOL_XL) : (x == CONV_XL);
    y_last = (state == S_POOL) ? (y == POOL_YL) : (y == CONV_YL);
    nx     = x_last ? '0 : x + ADDR_W'(1);
    ny     = x_last ? y + ADDR_W'(1) : y;
  end

  // Address of the tap to present next: tap k+1 of this pixel, or tap 0 of the next one.
  logic [ADDR_W-1:0] tx, ty, tap_addr;
  logic [3:0]        tk;
  int                ax, ay;

  always_comb begin
    tx = '0;
    ty = '0;
    tk = '0;
    if (state == S_CONV) begin
      if (phase == 4'd10) begin
        tx = nx;
        ty = ny;
      end else begin
        tx = x;
        ty = y;
        tk = phase + 4'd1;
      end
    end
    ax = int'(tx);
    ay = int'(ty);
    case (tk)
      4'd0, 4'd3, 4'd6: ax = ax - DILATION;
      4'd2, 4'd5, 4'd8: ax = ax + DILATION;
      default: ;
    endcase
    if (tk < 4'd3)      ay = ay - DILATION;
    else if (tk > 4'd5) ay = ay + DILATION;
    if (ax < 0)         ax = 0;
    if (ax > IMG_W - 1) ax = IMG_W - 1;
    if (ay < 0)         ay = 0;
    if (ay > IMG_H - 1) ay = IMG_H - 1;
    tap_addr = ADDR_W'(ay * IMG_W + ax);
  end

  logic [ADDR_W-1:0] qx, qy, rd_addr;
  logic [1:0]        q;

  always_comb begin
    qx = '0;
    qy = '0;
    q  = '0;
    if (state == S_POOL) begin
      if (phase == 4'd5) begin
        qx = nx;
        qy = ny;
      end else begin
        qx = x;
        qy = y;
        q  = 2'(phase + 4'd1);
      end
    end
    rd_addr = ADDR_W'((2*int'(qy) + int'(q[1])) * IMG_W + 2*int'(qx) + int'(q[0]));
  end

  // Tap captured in phase p is tap p-1: centre in phase 5, shifts of 3 / 2 / 4 elsewhere.
  logic signed [ACC_W-1:0]  tap_ext, term, conv_sum;
  logic signed [DATA_W-1:0] conv_res;

  always_comb begin
    tap_ext = {{4{bus.idata[DATA_W-1]}}, bus.idata};
    case (phase)
      4'd5:       term = tap_ext;
      4'd2, 4'd8: term = -(tap_ext >>> 3);
      4'd4, 4'd6: term = -(tap_ext >>> 2);
      default:    term = -(tap_ext >>> 4);
    endcase
    conv_sum = acc + term + BIAS_A;
    if (conv_sum[ACC_W-1])   conv_res = '0;
    else if (conv_sum > MAX_A) conv_res = DATA_W'(MAX_V);
    else                     conv_res = conv_sum[DATA_W-1:0];
  end

  logic signed [DATA_W-1:0] mx_base, rd_max, pool_res;
  logic [DATA_W:0]          rnd_sum, rnd_trunc;

  always_comb begin
    mx_base   = (phase == 4'd1) ? '0 : mx;
    rd_max    = (bus.cdata_rd > mx_base) ? bus.cdata_rd : mx_base;
    rnd_sum   = {1'b0, rd_max} + RND_U;
    rnd_trunc = rnd_sum & ~RND_U;
    pool_res  = (rnd_trunc > MAX_U) ? DATA_W'(MAX_V) : rnd_trunc[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      phase        <= '0;
      x            <= '0;
      y            <= '0;
      pix          <= '0;
      acc          <= '0;
      mx           <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.cwr      <= 1'b0;
      bus.crd      <= 1'b0;
      bus.csel     <= 1'b0;
      bus.iaddr    <= '0;
      bus.caddr_wr <= '0;
      bus.caddr_rd <= '0;
      bus.cdata_wr <= '0;
    end else begin
      bus.cwr  <= 1'b0;
      bus.crd  <= 1'b0;
      bus.done <= 1'b0;
      bus.csel <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.ready) begin
            state     <= S_CONV;
            bus.busy  <= 1'b1;
            phase     <= '0;
            x         <= '0;
            y         <= '0;
            pix       <= '0;
            bus.iaddr <= tap_addr;
          end
        end
        S_CONV: begin
          phase <= phase + 4'd1;
          if (phase < 4'd8) bus.iaddr <= tap_addr;
          if (phase == 4'd0) acc <= '0;
          else if (phase <= 4'd8) acc <= acc + term;
          if (phase == 4'd9) begin
            bus.cwr      <= 1'b1;
            bus.cdata_wr <= conv_res;
            bus.caddr_wr <= pix;
          end
          if (phase == 4'd10) begin
            phase     <= '0;
            x         <= nx;
            y         <= ny;
            pix       <= pix + ADDR_W'(1);
            bus.iaddr <= tap_addr;
            if (x_last && y_last) begin
              x   <= '0;
              y   <= '0;
              pix <= '0;
              if (POOL_EN != 0) begin
                state        <= S_POOL;
                bus.crd      <= 1'b1;
                bus.caddr_rd <= rd_addr;
              end else begin
                state    <= S_DONE;
                bus.done <= 1'b1;
                bus.busy <= 1'b0;
              end
            end
          end
        end
        S_POOL: begin
          phase <= phase + 4'd1;
          if (phase < 4'd3) begin
            bus.crd      <= 1'b1;
            bus.caddr_rd <= rd_addr;
          end
          if (phase >= 4'd1 && phase <= 4'd4) mx <= rd_max;
          if (phase == 4'd4) begin
            bus.cwr      <= 1'b1;
            bus.csel     <= 1'b1;
            bus.cdata_wr <= pool_res;
            bus.caddr_wr <= pix;
          end
          if (phase == 4'd5) begin
            phase <= '0;
            x     <= nx;
            y     <= ny;
            pix   <= pix + ADDR_W'(1);
            if (x_last && y_last) begin
              state    <= S_DONE;
              bus.done <= 1'b1;
              bus.busy <= 1'b0;
            end else begin
              bus.crd      <= 1'b1;
              bus.caddr_rd <= rd_addr;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
